// File: rtl/c28soi_pm_cpr_freq_meter.sv
// CPR ring-oscillator frequency meter: powers selected oscillators, lets them settle,
// then counts synchronized rising edges of each divider output over a CLK-cycle window.

module c28soi_pm_cpr_freq_meter_lane #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             en,
    input  logic             cnt_phase,
    input  logic             clr,
    input  logic             load,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);
    // [0],[1] form the synchronizer, [2] is the edge-detect history
    logic [2:0]       sync_pipe;
    logic [CNT_W-1:0] work;
    logic [CNT_W-1:0] work_nxt;
    logic             work_ovf;
    logic             wovf_nxt;
    logic             rise;
    logic             inc;
    logic             at_max;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_pipe <= '0;
        else     sync_pipe <= {sync_pipe[1:0], din};
    end

    assign rise     = sync_pipe[1] & ~sync_pipe[2];
    assign inc      = rise & en & cnt_phase;
    assign at_max   = &work;
    assign work_nxt = (inc && !at_max) ? work + 1'b1 : work;
    assign wovf_nxt = work_ovf | (inc & at_max);

    // Results load from the next-state value so the final window cycle is included
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work     <= '0;
            work_ovf <= 1'b0;
            count    <= '0;
            ovf      <= 1'b0;
        end else begin
            if (clr) begin
                work     <= '0;
                work_ovf <= 1'b0;
            end else begin
                work     <= work_nxt;
                work_ovf <= wovf_nxt;
            end
            if (load) begin
                count <= work_nxt;
                ovf   <= wovf_nxt;
            end
        end
    end
endmodule

module c28soi_pm_cpr_freq_meter #(
    parameter int NCH        = 4,
    parameter int CNT_W      = 16,
    parameter int WIN_W      = 16,
    parameter int SETTLE_CYC = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic                 ABORT,
    input  logic [WIN_W-1:0]     WINDOW,
    input  logic [NCH-1:0]       CH_MASK,
    input  logic [NCH-1:0]       LOGICCPR,
    output logic [NCH-1:0]       CPR_EN,
    output logic                 CPR_RN,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [NCH*CNT_W-1:0] COUNT,
    output logic [NCH-1:0]       OVF
);
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_COUNT, S_DONE} state_t;

    typedef struct packed {
        logic [WIN_W-1:0] window;
        logic [NCH-1:0]   mask;
    } cfg_t;

    state_t                     state;
    cfg_t                       cfg_q;
    logic [SET_W-1:0]           settle_cnt;
    logic [WIN_W-1:0]           win_cnt;
    logic                       accept;
    logic                       settle_last;
    logic                       count_last;
    logic                       to_done;
    logic                       cnt_phase;
    logic [NCH-1:0][CNT_W-1:0]  cnt_arr;

    assign accept      = (state == S_IDLE) && START && !ABORT;
    assign settle_last = (state == S_SETTLE) && (settle_cnt == SET_W'(SETTLE_CYC - 1));
    assign count_last  = (state == S_COUNT) && (win_cnt == cfg_q.window - 1'b1);
    assign to_done     = !ABORT && ((settle_last && (cfg_q.window == '0)) || count_last);
    assign cnt_phase   = (state == S_COUNT);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_IDLE;
            cfg_q      <= '0;
            settle_cnt <= '0;
            win_cnt    <= '0;
            CPR_EN     <= '0;
            CPR_RN     <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state      <= S_SETTLE;
                        cfg_q      <= '{window: WINDOW, mask: CH_MASK};
                        settle_cnt <= '0;
                        CPR_EN     <= CH_MASK;
                        BUSY       <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (ABORT) begin
                        state  <= S_IDLE;
                        CPR_EN <= '0;
                        CPR_RN <= 1'b0;
                        BUSY   <= 1'b0;
                    end else if (settle_last) begin
                        if (cfg_q.window == '0) begin
                            state  <= S_DONE;
                            DONE   <= 1'b1;
                            CPR_EN <= '0;
                        end else begin
                            state   <= S_COUNT;
                            win_cnt <= '0;
                            CPR_RN  <= 1'b1;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                S_COUNT: begin
                    if (ABORT) begin
                        state  <= S_IDLE;
                        CPR_EN <= '0;
                        CPR_RN <= 1'b0;
                        BUSY   <= 1'b0;
                    end else if (count_last) begin
                        state  <= S_DONE;
                        DONE   <= 1'b1;
                        CPR_EN <= '0;
                        CPR_RN <= 1'b0;
                    end else begin
                        win_cnt <= win_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    BUSY  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        c28soi_pm_cpr_freq_meter_lane #(.CNT_W(CNT_W)) u_lane (
            .clk       (CLK),
            .rst       (RST),
            .din       (LOGICCPR[i]),
            .en        (cfg_q.mask[i]),
            .cnt_phase (cnt_phase),
            .clr       (accept),
            .load      (to_done),
            .count     (cnt_arr[i]),
            .ovf       (OVF[i])
        );
    end

    assign COUNT = cnt_arr;
endmodule

// File: tb/tb_c28soi_pm_cpr_freq_meter.sv
// Bench for the CPR frequency meter: table vectors, directed corner sequences and
// randomized periodic inputs scored against an edge-log reference model.

module tb_c28soi_pm_cpr_freq_meter;
    localparam int NCH    = 4;
    localparam int CNT_W  = 16;
    localparam int WIN_W  = 16;
    localparam int SETTLE = 8;
    localparam int NONE   = -100;

    logic                 CLK = 1'b0;
    logic                 RST = 1'b1;
    logic                 START = 1'b0;
    logic                 ABORT = 1'b0;
    logic [WIN_W-1:0]     WINDOW = '0;
    logic [NCH-1:0]       CH_MASK = '0;
    logic [NCH-1:0]       LOGICCPR = '0;

    logic [NCH-1:0]       cpr_en, cpr_en4;
    logic                 cpr_rn, cpr_rn4, busy, busy4, done, done4;
    logic [NCH*CNT_W-1:0] count;
    logic [NCH*4-1:0]     count4;
    logic [NCH-1:0]       ovf, ovf4;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0;
    int rn_cnt = 0;
    int rise_ch[$];
    int rise_n[$];

    typedef struct packed {
        logic [15:0]      w;
        logic [3:0]       m;
        logic [3:0][7:0]  per;
        logic [3:0][15:0] exp;
    } vec_t;

    c28soi_pm_cpr_freq_meter #(.NCH(NCH), .CNT_W(CNT_W), .WIN_W(WIN_W), .SETTLE_CYC(SETTLE)) dut (
        .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .WINDOW(WINDOW), .CH_MASK(CH_MASK),
        .LOGICCPR(LOGICCPR), .CPR_EN(cpr_en), .CPR_RN(cpr_rn), .BUSY(busy), .DONE(done),
        .COUNT(count), .OVF(ovf)
    );

    c28soi_pm_cpr_freq_meter #(.NCH(NCH), .CNT_W(4), .WIN_W(WIN_W), .SETTLE_CYC(SETTLE)) dut4 (
        .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .WINDOW(WINDOW), .CH_MASK(CH_MASK),
        .LOGICCPR(LOGICCPR), .CPR_EN(cpr_en4), .CPR_RN(cpr_rn4), .BUSY(busy4), .DONE(done4),
        .COUNT(count4), .OVF(ovf4)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (done)   done_cnt <= done_cnt + 1;
        if (cpr_rn) rn_cnt   <= rn_cnt + 1;
    end

    task automatic tick();
        @(posedge CLK);
        cyc++;
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Periodic square wave per channel, phase-referenced to the COUNT entry edge e;
    // every 0->1 transition is logged with the clock edge that first samples it.
    task automatic drive(input int e, input int per[NCH], input int off[NCH]);
        logic [NCH-1:0] nv;
        int d;
        for (int i = 0; i < NCH; i++) begin
            d = cyc + 1 - e - off[i];
            nv[i] = (per[i] > 0 && d >= 0) ? ((d % per[i]) < per[i] / 2) : 1'b0;
            if (nv[i] && !LOGICCPR[i]) begin
                rise_ch.push_back(i);
                rise_n.push_back(cyc + 1);
            end
        end
        LOGICCPR = nv;
    endtask

    task automatic measure(input int w, input logic [NCH-1:0] m, input int per[NCH],
                           input int off[NCH], input int abort_at, input bit restart);
        int s, e, dn, d0, r0, raw;
        bit aborted;
        logic [NCH*CNT_W-1:0] cnt_prev, exp16;
        logic [NCH*4-1:0]     exp4;
        logic [NCH-1:0]       ovf_prev, eo16, eo4;
        aborted = 1'b0;
        rise_ch.delete();
        rise_n.delete();
        cnt_prev = count;
        ovf_prev = ovf;
        d0 = done_cnt;
        r0 = rn_cnt;
        WINDOW = WIN_W'(w);
        CH_MASK = m;
        START = 1'b1;
        s = cyc + 1;
        e = s + SETTLE;
        dn = e + w;
        drive(e, per, off);
        while (cyc < dn && !aborted) begin
            tick();
            START = 1'b0;
            WINDOW = ~WINDOW;
            CH_MASK = ~CH_MASK;
            if (restart && (cyc == s + 1 || cyc == e)) START = 1'b1;
            if (cyc == s) chk("settle_outputs", {busy, cpr_rn, cpr_en}, {1'b1, 1'b0, m});
            if (w > 0 && cyc == e) chk("count_outputs", {busy, cpr_rn, cpr_en}, {1'b1, 1'b1, m});
            if (abort_at != NONE && cyc == e + abort_at) begin
                ABORT = 1'b1;
                aborted = 1'b1;
            end
            drive(e, per, off);
        end
        if (aborted) begin
            tick();
            ABORT = 1'b0;
            START = 1'b0;
            LOGICCPR = '0;
            chk("abort_busy", busy, 0);
            chk("abort_cpr_en", cpr_en, 0);
            chk("abort_cpr_rn", cpr_rn, 0);
            repeat (w + 4) tick();
            chk("abort_no_done", done_cnt - d0, 0);
            chk("abort_keep_count", count, cnt_prev);
            chk("abort_keep_ovf", ovf, ovf_prev);
        end else begin
            for (int i = 0; i < NCH; i++) begin
                raw = 0;
                for (int k = 0; k < rise_n.size(); k++)
                    if (rise_ch[k] == i && rise_n[k] >= e - 1 && rise_n[k] <= e + w - 2) raw++;
                if (!m[i]) raw = 0;
                exp16[i*16 +: 16] = (raw > 65535) ? 16'hFFFF : 16'(raw);
                eo16[i] = (raw > 65535);
                exp4[i*4 +: 4] = (raw > 15) ? 4'hF : 4'(raw);
                eo4[i] = (raw > 15);
            end
            chk("done_pulse", {done, done4}, 2'b11);
            chk("done_cpr_off", {cpr_en, cpr_rn}, 0);
            chk("count16", count, exp16);
            chk("ovf16", ovf, eo16);
            chk("count4", count4, exp4);
            chk("ovf4", ovf4, eo4);
            START = 1'b0;
            LOGICCPR = '0;
            tick();
            chk("idle_after_done", {busy, done}, 0);
            chk("one_done_per_start", done_cnt - d0, 1);
            if (w == 0) chk("rn_low_w0", rn_cnt - r0, 0);
            repeat (3) tick();
        end
    endtask

    initial begin
        vec_t vecs[5];
        int pa[NCH];
        int oa[NCH];
        int w, ab, d0;

        vecs[0] = '{w: 16'd100, m: 4'b1111, per: {8'd50, 8'd10, 8'd6, 8'd4}, exp: {16'd2, 16'd10, 16'd17, 16'd25}};
        vecs[1] = '{w: 16'd20,  m: 4'b1010, per: {8'd9, 8'd7, 8'd5, 8'd4},   exp: {16'd3, 16'd0, 16'd4, 16'd0}};
        vecs[2] = '{w: 16'd1,   m: 4'b1111, per: {8'd4, 8'd4, 8'd4, 8'd4},   exp: {16'd0, 16'd0, 16'd0, 16'd0}};
        vecs[3] = '{w: 16'd2,   m: 4'b0001, per: {8'd4, 8'd4, 8'd4, 8'd4},   exp: {16'd0, 16'd0, 16'd0, 16'd1}};
        vecs[4] = '{w: 16'd300, m: 4'b0100, per: {8'd4, 8'd8, 8'd4, 8'd4},   exp: {16'd0, 16'd38, 16'd0, 16'd0}};

        repeat (3) tick();
        chk("reset_ctl", {cpr_en, cpr_rn, busy, done, ovf, cpr_en4, cpr_rn4, busy4, done4, ovf4}, 0);
        chk("reset_count", {count, count4}, 0);
        RST = 1'b0;
        tick();

        // ch0 every 10 CLK, first rise 3 CLK into COUNT
        pa = '{10, 0, 0, 0};
        oa = '{3, 0, 0, 0};
        measure(100, 4'b0001, pa, oa, NONE, 1'b0);
        chk("s2_count0", count[15:0], 10);
        chk("s2_others", count[63:16], 0);
        chk("s2_ovf", ovf, 0);

        measure(150, 4'b0001, pa, oa, 20, 1'b0);
        chk("s4_keep_count0", count[15:0], 10);

        // asynchronous reset in the middle of a window
        WINDOW = 16'd50;
        CH_MASK = 4'hF;
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int k = 0; k < SETTLE + 10; k++) begin
            tick();
            LOGICCPR = ((k % 4) < 2) ? 4'hF : 4'h0;
        end
        chk("pre_rst_busy", {busy, cpr_rn}, 2'b11);
        #2 RST = 1'b1;
        #1;
        chk("rst_async_ctl", {cpr_en, cpr_rn, busy, done, ovf}, 0);
        chk("rst_async_count", count, 0);
        LOGICCPR = '0;
        tick();
        tick();
        RST = 1'b0;
        tick();
        chk("post_rst_idle", {busy, done, cpr_en, cpr_rn}, 0);

        pa = '{0, 0, 8, 0};
        oa = '{0, 0, 0, 0};
        measure(200, 4'b0100, pa, oa, NONE, 1'b0);
        chk("s3_count4_ch2", count4[11:8], 15);
        chk("s3_ovf4", ovf4, 4'b0100);
        chk("s3_count16_ch2", count[47:32], 25);

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < NCH; i++) begin
                pa[i] = int'(vecs[v].per[i]);
                oa[i] = 0;
            end
            measure(int'(vecs[v].w), vecs[v].m, pa, oa, NONE, 1'b0);
            chk($sformatf("vec%0d_count", v), count, vecs[v].exp);
            chk($sformatf("vec%0d_ovf", v), ovf, 0);
        end

        // zero window with every input toggling through SETTLE
        pa = '{4, 4, 6, 8};
        oa = '{-8, -7, -6, -5};
        measure(0, 4'b1111, pa, oa, NONE, 1'b0);
        chk("s5_count_zero", count, 0);

        pa = '{4, 6, 0, 12};
        oa = '{0, 2, 0, -3};
        measure(30, 4'b1011, pa, oa, NONE, 1'b1);

        d0 = done_cnt;
        START = 1'b1;
        ABORT = 1'b1;
        tick();
        START = 1'b0;
        ABORT = 1'b0;
        chk("start_abort_idle", busy, 0);
        repeat (SETTLE + 3) tick();
        chk("start_abort_no_done", done_cnt - d0, 0);

        for (int r = 0; r < 30; r++) begin
            w = int'($urandom_range(0, 120));
            for (int i = 0; i < NCH; i++) begin
                pa[i] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(4, 30));
                oa[i] = int'($urandom_range(0, 32)) - 12;
            end
            ab = NONE;
            if ($urandom_range(0, 4) == 0 && w > 0) ab = int'($urandom_range(0, w + SETTLE - 1)) - SETTLE;
            measure(w, 4'($urandom), pa, oa, ab, 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
